// File: rtl/lif_pkg.sv
// Shared definitions for the LIF spike-rate decoder: hex 7-segment codes,
// the default accumulator width and the window-control state encoding.
package lif_pkg;

    localparam int COUNT_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PAUSE = 2'd2
    } lif_state_e;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to 7-segment code; shared by every displayed digit.
module seg7_hex_decoder
    import lif_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] segments
);

    assign segments = SEG_HEX[value];

endmodule

// File: rtl/lif_spike_rate_decoder.sv
// Counts rising edges of the neuron spike over a window of enabled cycles and
// latches the (saturating) count as a rate shown on a 7-segment digit.
module lif_spike_rate_decoder
    import lif_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int COUNT_W       = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               spike_in,
    input  logic               clear,
    output logic [COUNT_W-1:0] rate,
    output logic               rate_valid,
    output logic               overflow,
    output logic [6:0]         segments
);

    localparam int                 WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0]   WIN_ONE  = WIN_W'(1);
    localparam logic [WIN_W-1:0]   WIN_ZERO = WIN_W'(0);
    localparam logic [COUNT_W-1:0] ACC_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] ACC_ONE  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] ACC_ZERO = COUNT_W'(0);

    lif_state_e         state_r;
    lif_state_e         state_s;
    logic               spike_q_r;
    logic [WIN_W-1:0]   win_cnt_r;
    logic [WIN_W-1:0]   win_cnt_s;
    logic [COUNT_W-1:0] acc_r;
    logic [COUNT_W-1:0] acc_s;
    logic [COUNT_W-1:0] acc_next_s;
    logic               sat_r;
    logic               sat_s;
    logic               sat_next_s;
    logic [COUNT_W-1:0] rate_r;
    logic [COUNT_W-1:0] rate_s;
    logic               valid_r;
    logic               valid_s;
    logic               ovf_r;
    logic               ovf_s;
    logic               spike_edge_s;
    logic               count_en_s;
    logic               terminal_s;
    logic [3:0]         digit_s;

    // Every enabled, non-cleared cycle is a window cycle, including the
    // cycle that leaves IDLE or PAUSE.
    assign spike_edge_s = spike_in & ~spike_q_r;
    assign count_en_s   = ena & ~clear;
    assign terminal_s   = count_en_s & (win_cnt_r == WIN_LAST);

    // Next-state logic for the window-control FSM
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ena) state_s = COUNT;
                    else     state_s = IDLE;
                end
                COUNT: begin
                    if (!ena) state_s = PAUSE;
                    else      state_s = COUNT;
                end
                PAUSE: begin
                    if (ena) state_s = COUNT;
                    else     state_s = PAUSE;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // Saturating accumulator view including this cycle's edge
    always_comb begin
        acc_next_s = acc_r;
        sat_next_s = sat_r;
        if (count_en_s && spike_edge_s) begin
            if (acc_r < ACC_MAX) begin
                acc_next_s = acc_r + ACC_ONE;
            end else begin
                sat_next_s = 1'b1;
            end
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Window, accumulator and rate-latch next values; clear beats terminal
    always_comb begin
        win_cnt_s = win_cnt_r;
        acc_s     = acc_r;
        sat_s     = sat_r;
        rate_s    = rate_r;
        ovf_s     = ovf_r;
        valid_s   = 1'b0;
        if (clear) begin
            win_cnt_s = WIN_ZERO;
            acc_s     = ACC_ZERO;
            sat_s     = 1'b0;
            rate_s    = ACC_ZERO;
            ovf_s     = 1'b0;
        end else if (terminal_s) begin
            win_cnt_s = WIN_ZERO;
            acc_s     = ACC_ZERO;
            sat_s     = 1'b0;
            rate_s    = acc_next_s;
            ovf_s     = sat_next_s;
            valid_s   = 1'b1;
        end else if (count_en_s) begin
            win_cnt_s = win_cnt_r + WIN_ONE;
            acc_s     = acc_next_s;
            sat_s     = sat_next_s;
        end else begin
            win_cnt_s = win_cnt_r;
        end
    end

    // State registers; the spike sampler runs regardless of ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            spike_q_r <= 1'b0;
            win_cnt_r <= WIN_ZERO;
            acc_r     <= ACC_ZERO;
            sat_r     <= 1'b0;
            rate_r    <= ACC_ZERO;
            valid_r   <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            spike_q_r <= spike_in;
            win_cnt_r <= win_cnt_s;
            acc_r     <= acc_s;
            sat_r     <= sat_s;
            rate_r    <= rate_s;
            valid_r   <= valid_s;
            ovf_r     <= ovf_s;
        end
    end

    if (COUNT_W >= 4) begin : g_digit_trunc
        assign digit_s = rate_r[3:0];
    end else begin : g_digit_pad
        assign digit_s = {{(4 - COUNT_W){1'b0}}, rate_r};
    end

    seg7_hex_decoder u_seg (
        .value    (digit_s),
        .segments (segments)
    );

    assign rate       = rate_r;
    assign rate_valid = valid_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a window-level reference model, on 16- and 64-cycle instances.
module tb_lif_spike_rate_decoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       spike_in;
    logic       clear;
    logic [3:0] rate16, rate64;
    logic       valid16, valid64;
    logic       ovf16, ovf64;
    logic [6:0] seg16, seg64;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state, index 0 = 16-cycle window, 1 = 64-cycle window
    int   win_len [2] = '{16, 64};
    int   m_cnt   [2];
    int   m_edges [2];
    int   m_rate  [2];
    logic m_valid [2];
    logic m_ovf   [2];
    logic m_prev;

    lif_spike_rate_decoder #(.WINDOW_CYCLES(16), .COUNT_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .clear(clear),
        .rate(rate16), .rate_valid(valid16), .overflow(ovf16), .segments(seg16)
    );

    lif_spike_rate_decoder #(.WINDOW_CYCLES(64), .COUNT_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .clear(clear),
        .rate(rate64), .rate_valid(valid64), .overflow(ovf64), .segments(seg64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_prev = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_edges[d] = 0; m_rate[d] = 0;
            m_valid[d] = 1'b0; m_ovf[d] = 1'b0;
        end
    endtask

    // Rate = number of rising edges seen in the last WINDOW enabled cycles
    task automatic model_step(input logic e, input logic s, input logic c);
        int edge_seen;
        edge_seen = (s && !m_prev) ? 1 : 0;
        m_prev = s;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            if (c) begin
                m_cnt[d] = 0; m_edges[d] = 0; m_rate[d] = 0; m_ovf[d] = 1'b0;
            end else if (e) begin
                m_edges[d] += edge_seen;
                m_cnt[d]++;
                if (m_cnt[d] == win_len[d]) begin
                    m_rate[d]  = (m_edges[d] > 15) ? 15 : m_edges[d];
                    m_ovf[d]   = (m_edges[d] > 15);
                    m_valid[d] = 1'b1;
                    m_cnt[d] = 0; m_edges[d] = 0;
                end
            end
        end
    endtask

    task automatic tick(input logic e, input logic s, input logic c);
        ena = e; spike_in = s; clear = c;
        model_step(e, s, c);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; clear = 1'b0; spike_in = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            spike_in = i[0];
            @(posedge clk);
            #1;
            n_cmp += 4;
            if (rate16 !== 4'd0 || rate64 !== 4'd0) begin
                n_fail++; $display("FAIL reset_rate: got %0d/%0d expected 0", rate16, rate64);
            end
            if (valid16 !== 1'b0 || valid64 !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid: got %b/%b expected 0", valid16, valid64);
            end
            if (ovf16 !== 1'b0 || ovf64 !== 1'b0) begin
                n_fail++; $display("FAIL reset_ovf: got %b/%b expected 0", ovf16, ovf64);
            end
            if (seg16 !== 7'h3F || seg64 !== 7'h3F) begin
                n_fail++; $display("FAIL reset_seg: got %h/%h expected 3f", seg16, seg64);
            end
        end
        ena = 1'b0; spike_in = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_three_spikes();
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 32; k++) begin
            tick(1'b1, (k == 2 || k == 5 || k == 15), 1'b0);
            n_cmp++;
            if (valid16 !== (k == 15 || k == 31)) begin
                n_fail++; $display("FAIL three_valid k=%0d: got %b", k, valid16);
            end
            if (k == 15) begin
                n_cmp += 3;
                if (rate16 !== 4'd3) begin n_fail++; $display("FAIL three_rate: got %0d expected 3", rate16); end
                if (seg16 !== 7'h4F) begin n_fail++; $display("FAIL three_seg: got %h expected 4f", seg16); end
                if (ovf16 !== 1'b0)  begin n_fail++; $display("FAIL three_ovf: got %b expected 0", ovf16); end
            end
            if (k == 31) begin
                n_cmp++;
                if (rate16 !== 4'd0) begin n_fail++; $display("FAIL empty_rate: got %0d expected 0", rate16); end
            end
        end
    endtask

    task automatic test_held_spike();
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) tick(1'b1, (k >= 3 && k <= 12), 1'b0);
        n_cmp += 2;
        if (valid16 !== 1'b1) begin n_fail++; $display("FAIL held_valid: got %b expected 1", valid16); end
        if (rate16 !== 4'd1)  begin n_fail++; $display("FAIL held_rate: got %0d expected 1", rate16); end
    endtask

    task automatic test_saturation();
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 128; k++) begin
            if (k < 64) tick(1'b1, (k < 40 && k % 2 == 0), 1'b0);
            else        tick(1'b1, (k - 64 < 8 && k % 2 == 0), 1'b0);
            n_cmp++;
            if (valid64 !== (k == 63 || k == 127)) begin
                n_fail++; $display("FAIL sat_valid k=%0d: got %b", k, valid64);
            end
            if (k == 63) begin
                n_cmp += 3;
                if (rate64 !== 4'd15) begin n_fail++; $display("FAIL sat_rate: got %0d expected 15", rate64); end
                if (ovf64 !== 1'b1)   begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", ovf64); end
                if (seg64 !== 7'h71)  begin n_fail++; $display("FAIL sat_seg: got %h expected 71", seg64); end
            end
            if (k == 127) begin
                n_cmp += 3;
                if (rate64 !== 4'd4) begin n_fail++; $display("FAIL post_sat_rate: got %0d expected 4", rate64); end
                if (ovf64 !== 1'b0)  begin n_fail++; $display("FAIL post_sat_ovf: got %b expected 0", ovf64); end
                if (seg64 !== 7'h66) begin n_fail++; $display("FAIL post_sat_seg: got %h expected 66", seg64); end
            end
        end
    endtask

    task automatic test_pause();
        tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 24; c++) begin
            tick(!(c >= 7 && c <= 11), (c == 2 || c == 9 || c == 15), 1'b0);
            n_cmp++;
            if (valid16 !== (c == 20)) begin
                n_fail++; $display("FAIL pause_valid c=%0d: got %b", c, valid16);
            end
            if (c == 20) begin
                n_cmp++;
                if (rate16 !== 4'd2) begin n_fail++; $display("FAIL pause_rate: got %0d expected 2", rate16); end
            end
        end
    endtask

    // Leaves a nonzero rate latched, then clears on the terminal cycle
    task automatic test_clear_terminal();
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) tick(1'b1, (k == 1 || k == 3), 1'b0);
        n_cmp++;
        if (rate16 !== 4'd2) begin n_fail++; $display("FAIL pre_clear_rate: got %0d expected 2", rate16); end
        for (int k = 0; k < 15; k++) tick(1'b1, (k < 10 && k % 2 == 1), 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_cmp += 3;
            if (valid16 !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %b expected 0", valid16); end
            if (rate16 !== 4'd0)  begin n_fail++; $display("FAIL clear_rate: got %0d expected 0", rate16); end
            if (seg16 !== 7'h3F)  begin n_fail++; $display("FAIL clear_seg: got %h expected 3f", seg16); end
            tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_window();
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) tick(1'b1, (k == 1 || k == 3 || k == 5), 1'b0);
        rst_n = 1'b0; ena = 1'b1; spike_in = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if (valid16 !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", valid16); end
        ena = 1'b0; spike_in = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick(1'b1, (k == 4), 1'b0);
            n_cmp++;
            if (valid16 !== (k == 15)) begin
                n_fail++; $display("FAIL restart_valid k=%0d: got %b", k, valid16);
            end
        end
        n_cmp++;
        if (rate16 !== 4'd1) begin n_fail++; $display("FAIL restart_rate: got %0d expected 1", rate16); end
    endtask

    task automatic test_random();
        int density;
        logic [3:0] a_rate;
        logic       a_valid, a_ovf;
        logic [6:0] a_seg;
        tick(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 1200; n++) begin
            if (n % 200 == 0) density = $urandom_range(1, 9);
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 9) < density,
                 $urandom_range(0, 299) == 0);
            for (int d = 0; d < 2; d++) begin
                a_rate  = (d == 0) ? rate16  : rate64;
                a_valid = (d == 0) ? valid16 : valid64;
                a_ovf   = (d == 0) ? ovf16   : ovf64;
                a_seg   = (d == 0) ? seg16   : seg64;
                n_cmp += 4;
                if (a_rate !== 4'(m_rate[d])) begin
                    n_fail++; $display("FAIL rand_rate w=%0d n=%0d: got %0d expected %0d", win_len[d], n, a_rate, m_rate[d]);
                end
                if (a_valid !== m_valid[d]) begin
                    n_fail++; $display("FAIL rand_valid w=%0d n=%0d: got %b expected %b", win_len[d], n, a_valid, m_valid[d]);
                end
                if (a_ovf !== m_ovf[d]) begin
                    n_fail++; $display("FAIL rand_ovf w=%0d n=%0d: got %b expected %b", win_len[d], n, a_ovf, m_ovf[d]);
                end
                if (a_seg !== seg_of(m_rate[d])) begin
                    n_fail++; $display("FAIL rand_seg w=%0d n=%0d: got %h expected %h", win_len[d], n, a_seg, seg_of(m_rate[d]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_spikes();
        test_held_spike();
        test_saturation();
        test_pause();
        test_clear_terminal();
        test_reset_mid_window();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
